branch_resolve_unit: RTL and testbench

BRANCH_RESOLVE_UNIT -- requirements
Module: branch_resolve_unit

---
 rtl/branch_resolve_unit.sv | 178 +++++++++++++++++
 tb/tb_branch_resolve_unit.sv | 343 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/branch_resolve_unit.sv
// Branch resolution: shadows fetch predictions to MEM, detects
// mispredicts, redirects/flushes fetch, trains the BTB, counts events.
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   stall               freezes shadow stages and resolution
//   if_*                fetch slot: valid, pc, predicted taken/target
//   mem_*               MEM-stage resolved branch info
//   btb_*               predictor training port (one-cycle btb_is_branch)
//   redirect_valid/pc   fetch correction, one-cycle pulse
//   flush               kill younger in-flight instructions
//   branch_count        resolved conditional branches
//   mispredict_count    detected mispredicts
module branch_resolve_unit (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        if_valid,
  input  logic [31:0] if_pc,
  input  logic        if_pred_taken,
  input  logic [31:0] if_pred_target,
  input  logic        mem_is_branch,
  input  logic        mem_actual_taken,
  input  logic [31:0] mem_actual_target,
  output logic [31:0] btb_pc_update,
  output logic [31:0] btb_actual_target,
  output logic        btb_actual_taken,
  output logic        btb_is_branch,
  output logic        redirect_valid,
  output logic [31:0] redirect_pc,
  output logic        flush,
  output logic [31:0] branch_count,
  output logic [31:0] mispredict_count
);

  logic        s1_v_q, s1_v_d;
  logic [31:0] s1_pc_q, s1_pc_d;
  logic        s1_pt_q, s1_pt_d;
  logic [31:0] s1_tg_q, s1_tg_d;
  logic        s2_v_q, s2_v_d;
  logic [31:0] s2_pc_q, s2_pc_d;
  logic        s2_pt_q, s2_pt_d;
  logic [31:0] s2_tg_q, s2_tg_d;
  logic        s3_v_q, s3_v_d;
  logic [31:0] s3_pc_q, s3_pc_d;
  logic        s3_pt_q, s3_pt_d;
  logic [31:0] s3_tg_q, s3_tg_d;

  logic        rv_q, rv_d;
  logic        fl_q, fl_d;
  logic [31:0] rpc_q, rpc_d;
  logic        bi_q, bi_d;
  logic        btk_q, btk_d;
  logic [31:0] bpc_q, bpc_d;
  logic [31:0] btg_q, btg_d;
  logic [31:0] bc_q, bc_d;
  logic [31:0] mc_q, mc_d;

  logic        actual;
  logic        resolve;
  logic        tgt_miss;
  logic        mispred;
  logic        upd;
  logic [31:0] corr_pc;

  always_comb begin
    actual   = mem_is_branch & mem_actual_taken;
    resolve  = s3_v_q & ~stall;
    tgt_miss = s3_pt_q & actual &
               (s3_tg_q != mem_actual_target);
    mispred  = resolve &
               ((s3_pt_q != actual) | tgt_miss);
    upd      = resolve & mem_is_branch;
    corr_pc  = actual ? mem_actual_target
                      : s3_pc_q + 32'd4;

    s1_v_d  = s1_v_q;
    s1_pc_d = s1_pc_q;
    s1_pt_d = s1_pt_q;
    s1_tg_d = s1_tg_q;
    s2_v_d  = s2_v_q;
    s2_pc_d = s2_pc_q;
    s2_pt_d = s2_pt_q;
    s2_tg_d = s2_tg_q;
    s3_v_d  = s3_v_q;
    s3_pc_d = s3_pc_q;
    s3_pt_d = s3_pt_q;
    s3_tg_d = s3_tg_q;

    if (!stall) begin
      // fetch during the flush cycle is still wrong-path
      s1_v_d  = if_valid & ~mispred & ~fl_q;
      s1_pc_d = if_pc;
      s1_pt_d = if_pred_taken;
      s1_tg_d = if_pred_target;
      s2_v_d  = s1_v_q & ~mispred;
      s2_pc_d = s1_pc_q;
      s2_pt_d = s1_pt_q;
      s2_tg_d = s1_tg_q;
      // S2 holds a younger instruction, killed too
      s3_v_d  = s2_v_q & ~mispred;
      s3_pc_d = s2_pc_q;
      s3_pt_d = s2_pt_q;
      s3_tg_d = s2_tg_q;
    end

    rv_d  = mispred;
    fl_d  = mispred;
    rpc_d = mispred ? corr_pc : rpc_q;

    bi_d  = upd;
    bpc_d = upd ? s3_pc_q : bpc_q;
    btg_d = upd ? mem_actual_target : btg_q;
    btk_d = upd ? mem_actual_taken : btk_q;

    bc_d = bc_q + {31'd0, upd};
    mc_d = mc_q + {31'd0, mispred};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_v_q  <= 1'b0;
      s1_pc_q <= '0;
      s1_pt_q <= 1'b0;
      s1_tg_q <= '0;
      s2_v_q  <= 1'b0;
      s2_pc_q <= '0;
      s2_pt_q <= 1'b0;
      s2_tg_q <= '0;
      s3_v_q  <= 1'b0;
      s3_pc_q <= '0;
      s3_pt_q <= 1'b0;
      s3_tg_q <= '0;
      rv_q    <= 1'b0;
      fl_q    <= 1'b0;
      rpc_q   <= '0;
      bi_q    <= 1'b0;
      btk_q   <= 1'b0;
      bpc_q   <= '0;
      btg_q   <= '0;
      bc_q    <= '0;
      mc_q    <= '0;
    end else begin
      s1_v_q  <= s1_v_d;
      s1_pc_q <= s1_pc_d;
      s1_pt_q <= s1_pt_d;
      s1_tg_q <= s1_tg_d;
      s2_v_q  <= s2_v_d;
      s2_pc_q <= s2_pc_d;
      s2_pt_q <= s2_pt_d;
      s2_tg_q <= s2_tg_d;
      s3_v_q  <= s3_v_d;
      s3_pc_q <= s3_pc_d;
      s3_pt_q <= s3_pt_d;
      s3_tg_q <= s3_tg_d;
      rv_q    <= rv_d;
      fl_q    <= fl_d;
      rpc_q   <= rpc_d;
      bi_q    <= bi_d;
      btk_q   <= btk_d;
      bpc_q   <= bpc_d;
      btg_q   <= btg_d;
      bc_q    <= bc_d;
      mc_q    <= mc_d;
    end
  end

  assign btb_pc_update     = bpc_q;
  assign btb_actual_target = btg_q;
  assign btb_actual_taken  = btk_q;
  assign btb_is_branch     = bi_q;
  assign redirect_valid    = rv_q;
  assign redirect_pc       = rpc_q;
  assign flush             = fl_q;
  assign branch_count      = bc_q;
  assign mispredict_count  = mc_q;

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Self-checking bench for branch_resolve_unit: table vectors,
// random vectors, kill, stall and reset-mid-flush sequences.
module tb_branch_resolve_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall;
  logic        if_valid;
  logic [31:0] if_pc;
  logic        if_pred_taken;
  logic [31:0] if_pred_target;
  logic        mem_is_branch;
  logic        mem_actual_taken;
  logic [31:0] mem_actual_target;
  logic [31:0] btb_pc_update;
  logic [31:0] btb_actual_target;
  logic        btb_actual_taken;
  logic        btb_is_branch;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        flush;
  logic [31:0] branch_count;
  logic [31:0] mispredict_count;

  branch_resolve_unit dut (
    .clk               (clk),
    .rst               (rst),
    .stall             (stall),
    .if_valid          (if_valid),
    .if_pc             (if_pc),
    .if_pred_taken     (if_pred_taken),
    .if_pred_target    (if_pred_target),
    .mem_is_branch     (mem_is_branch),
    .mem_actual_taken  (mem_actual_taken),
    .mem_actual_target (mem_actual_target),
    .btb_pc_update     (btb_pc_update),
    .btb_actual_target (btb_actual_target),
    .btb_actual_taken  (btb_actual_taken),
    .btb_is_branch     (btb_is_branch),
    .redirect_valid    (redirect_valid),
    .redirect_pc       (redirect_pc),
    .flush             (flush),
    .branch_count      (branch_count),
    .mispredict_count  (mispredict_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc;
    logic        pt;
    logic [31:0] ptgt;
    logic        br;
    logic        at;
    logic [31:0] atgt;
    logic        x_redir;
    logic [31:0] x_rpc;
  } vec_t;

  typedef struct {
    logic        redir;
    logic [31:0] rpc;
    logic        btb;
    logic [31:0] bpc;
    logic [31:0] btgt;
    logic        btk;
  } exp_t;

  exp_t        sb[$];
  vec_t        tbl[8];
  int          checks = 0;
  int          errors = 0;
  logic [31:0] exp_bc = 0;
  logic [31:0] exp_mc = 0;

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h",
               name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic garbage_mem();
    mem_is_branch     = 1'($urandom);
    mem_actual_taken  = 1'($urandom);
    mem_actual_target = $urandom;
  endtask

  task automatic garbage_if();
    if_valid       = 1'b0;
    if_pc          = $urandom;
    if_pred_taken  = 1'($urandom);
    if_pred_target = $urandom;
  endtask

  function automatic exp_t from_vec(input vec_t v);
    exp_t e;
    e.redir = v.x_redir;
    e.rpc   = v.x_rpc;
    e.btb   = v.br;
    e.bpc   = v.pc;
    e.btgt  = v.atgt;
    e.btk   = v.at;
    return e;
  endfunction

  function automatic vec_t ref_model(input vec_t v);
    vec_t r;
    logic a;
    r = v;
    a = v.br & v.at;
    r.x_redir = (v.pt != a) |
                (v.pt & a & (v.ptgt != v.atgt));
    r.x_rpc = a ? v.atgt : v.pc + 32'd4;
    return r;
  endfunction

  task automatic check_resolved(input string tag);
    exp_t e;
    if (sb.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL %s scoreboard empty", tag);
      return;
    end
    e = sb.pop_front();
    if (e.redir) exp_mc++;
    if (e.btb) exp_bc++;
    chk({tag, ".redirect_valid"}, 32'(redirect_valid),
        32'(e.redir));
    chk({tag, ".flush"}, 32'(flush), 32'(e.redir));
    if (e.redir)
      chk({tag, ".redirect_pc"}, redirect_pc, e.rpc);
    chk({tag, ".btb_is_branch"}, 32'(btb_is_branch),
        32'(e.btb));
    if (e.btb) begin
      chk({tag, ".btb_pc"}, btb_pc_update, e.bpc);
      chk({tag, ".btb_tgt"}, btb_actual_target, e.btgt);
      chk({tag, ".btb_tk"}, 32'(btb_actual_taken),
          32'(e.btk));
    end
    chk({tag, ".branch_count"}, branch_count, exp_bc);
    chk({tag, ".mispredict_count"}, mispredict_count,
        exp_mc);
  endtask

  task automatic check_idle(input string tag);
    chk({tag, ".idle_redirect"}, 32'(redirect_valid), 0);
    chk({tag, ".idle_flush"}, 32'(flush), 0);
    chk({tag, ".idle_btb"}, 32'(btb_is_branch), 0);
    chk({tag, ".idle_bc"}, branch_count, exp_bc);
    chk({tag, ".idle_mc"}, mispredict_count, exp_mc);
  endtask

  task automatic fetch(input vec_t v);
    if_valid       = 1'b1;
    if_pc          = v.pc;
    if_pred_taken  = v.pt;
    if_pred_target = v.ptgt;
  endtask

  task automatic drive_mem(input vec_t v);
    mem_is_branch     = v.br;
    mem_actual_taken  = v.at;
    mem_actual_target = v.atgt;
  endtask

  task automatic run_vec(input vec_t v, input string tag);
    fetch(v);
    garbage_mem();
    tick();
    garbage_if();
    garbage_mem();
    tick();
    garbage_mem();
    tick();
    drive_mem(v);
    sb.push_back(from_vec(v));
    tick();
    check_resolved(tag);
    garbage_mem();
    tick();
    check_idle(tag);
  endtask

  initial begin
    vec_t v;
    vec_t y;
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    vec_t v;
    vec_t y;
    logic [31:0] pool [4];
    pool[0] = 32'h1000;
    pool[1] = 32'h2000;
    pool[2] = 32'h3000;
    pool[3] = 32'h4000;

    tbl[0] = '{32'h100, 0, 32'h0, 1, 0, 32'h180,
               0, 32'h0};
    tbl[1] = '{32'h200, 0, 32'h0, 1, 1, 32'h400,
               1, 32'h400};
    tbl[2] = '{32'h240, 1, 32'h500, 1, 1, 32'h600,
               1, 32'h600};
    tbl[3] = '{32'h300, 1, 32'h800, 0, 1, 32'h900,
               1, 32'h304};
    tbl[4] = '{32'h400, 1, 32'h700, 1, 1, 32'h700,
               0, 32'h0};
    tbl[5] = '{32'h500, 1, 32'h600, 1, 0, 32'h600,
               1, 32'h504};
    tbl[6] = '{32'hFFFFFFFC, 1, 32'h10, 1, 0, 32'h10,
               1, 32'h0};
    tbl[7] = '{32'h600, 0, 32'h0, 0, 0, 32'h0,
               0, 32'h0};

    rst = 1'b1;
    stall = 1'b0;
    garbage_if();
    garbage_mem();
    tick();
    tick();
    rst = 1'b0;
    chk("rst.redirect_valid", 32'(redirect_valid), 0);
    chk("rst.flush", 32'(flush), 0);
    chk("rst.btb_is_branch", 32'(btb_is_branch), 0);
    chk("rst.redirect_pc", redirect_pc, 0);
    chk("rst.btb_pc", btb_pc_update, 0);
    chk("rst.branch_count", branch_count, 0);
    chk("rst.mispredict_count", mispredict_count, 0);
    tick();
    check_idle("post_rst");

    for (int i = 0; i < 8; i++)
      run_vec(tbl[i], $sformatf("tbl%0d", i));

    for (int i = 0; i < 20; i++) begin
      v.pc   = $urandom & 32'hFFFF_FFFC;
      v.pt   = 1'($urandom);
      v.ptgt = pool[$urandom_range(0, 3)];
      v.br   = 1'($urandom);
      v.at   = 1'($urandom);
      v.atgt = pool[$urandom_range(0, 3)];
      v = ref_model(v);
      run_vec(v, $sformatf("rnd%0d", i));
    end

    // mispredict kills younger in-flight and flush-cycle fetch
    v = '{32'h200, 0, 32'h0, 1, 1, 32'h400, 1, 32'h400};
    y = '{32'h204, 0, 32'h0, 0, 0, 32'h0, 0, 32'h0};
    fetch(v);
    tick();
    y.pc = 32'h204;
    fetch(y);
    tick();
    y.pc = 32'h208;
    fetch(y);
    tick();
    y.pc = 32'h20C;
    fetch(y);
    drive_mem(v);
    sb.push_back(from_vec(v));
    tick();
    check_resolved("kill");
    y.pc = 32'h404;
    fetch(y);
    mem_is_branch     = 1'b1;
    mem_actual_taken  = 1'b1;
    mem_actual_target = 32'h999;
    tick();
    garbage_if();
    for (int i = 0; i < 6; i++) begin
      check_idle($sformatf("kill_idle%0d", i));
      tick();
    end

    // stall holds S3 and blocks resolution
    v = '{32'h700, 0, 32'h0, 1, 1, 32'h740, 1, 32'h740};
    fetch(v);
    tick();
    garbage_if();
    tick();
    tick();
    stall = 1'b1;
    drive_mem(v);
    for (int i = 0; i < 4; i++) begin
      tick();
      check_idle($sformatf("stall%0d", i));
    end
    stall = 1'b0;
    sb.push_back(from_vec(v));
    tick();
    check_resolved("stall_release");
    tick();
    check_idle("stall_once");

    // reset in the redirect cycle
    v = '{32'h800, 0, 32'h0, 1, 1, 32'hA00, 1, 32'hA00};
    fetch(v);
    tick();
    fetch(y);
    tick();
    tick();
    drive_mem(v);
    sb.push_back(from_vec(v));
    tick();
    check_resolved("pre_rst");
    rst = 1'b1;
    tick();
    rst = 1'b0;
    exp_bc = 0;
    exp_mc = 0;
    garbage_if();
    chk("rstmid.redirect_valid", 32'(redirect_valid), 0);
    chk("rstmid.flush", 32'(flush), 0);
    chk("rstmid.redirect_pc", redirect_pc, 0);
    chk("rstmid.btb_is_branch", 32'(btb_is_branch), 0);
    chk("rstmid.btb_tgt", btb_actual_target, 0);
    chk("rstmid.btb_tk", 32'(btb_actual_taken), 0);
    chk("rstmid.branch_count", branch_count, 0);
    chk("rstmid.mispredict_count", mispredict_count, 0);
    for (int i = 0; i < 4; i++) begin
      tick();
      check_idle($sformatf("rstmid_idle%0d", i));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
